fft_stage_seq: RTL

- Sequencer for an in-place radix-2 DIF FFT, N = 2..256, built around one shared butterfly2 datapath and a dual-port sample RAM. Each sample word is 34 bits.
- Per cycle it issues one butterfly: read address pair (a, b) and a W256 twiddle exponent (rot).
- It delays the address pair by the datapath latency to drive write-back, drains between stages, and signals frame completion.

---
 rtl/fft_ctrl_pkg.sv | 18 +
 rtl/fft_stage_seq_if.sv | 48 ++++
 rtl/fft_addr_gen.sv | 37 +++
 rtl/fft_stage_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the radix-2 DIF FFT stage sequencer.
// Optional per-stage scaling is enabled by the FFT_STAGE_SCALE_EN macro.
package fft_ctrl_pkg;

    localparam int unsigned DATA_W    = 34;
    localparam int unsigned ROT_W     = 7;
    localparam int unsigned MAX_LOG2N = 8;
    localparam int unsigned ADDR_W    = MAX_LOG2N;
    localparam int unsigned LOG2N_W   = 4;
    localparam int unsigned STAGE_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fft_stage_seq_if.sv
// Control, issue and write-back bus of the FFT stage sequencer.
// scale_mask/wr_scale exist only when FFT_STAGE_SCALE_EN is defined.
interface fft_stage_seq_if #(
    parameter int unsigned ADDR_W = fft_ctrl_pkg::ADDR_W,
    parameter int unsigned ROT_W  = fft_ctrl_pkg::ROT_W
);
    import fft_ctrl_pkg::*;

    logic                 start;
    logic [LOG2N_W-1:0]   log2n;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;
    logic [STAGE_W-1:0]   stage;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr_a;
    logic [ADDR_W-1:0]    rd_addr_b;
    logic [ROT_W-1:0]     rot;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr_a;
    logic [ADDR_W-1:0]    wr_addr_b;
`ifdef FFT_STAGE_SCALE_EN
    logic [MAX_LOG2N-1:0] scale_mask;
    logic                 wr_scale;
`endif

    modport master (
        output start, log2n, abort,
`ifdef FFT_STAGE_SCALE_EN
        output scale_mask,
        input  wr_scale,
`endif
        input  busy, done, cfg_err, stage, rd_en, rd_addr_a, rd_addr_b, rot,
        input  wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        input  start, log2n, abort,
`ifdef FFT_STAGE_SCALE_EN
        input  scale_mask,
        output wr_scale,
`endif
        output busy, done, cfg_err, stage, rd_en, rd_addr_a, rd_addr_b, rot,
        output wr_en, wr_addr_a, wr_addr_b
    );

endinterface

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address pair and W256 twiddle exponent
// for stage s, butterfly k of a 2^log2n point DIF FFT.
module fft_addr_gen #(
    parameter int unsigned MAX_LOG2N = fft_ctrl_pkg::MAX_LOG2N,
    parameter int unsigned ADDR_W    = fft_ctrl_pkg::ADDR_W,
    parameter int unsigned ROT_W     = fft_ctrl_pkg::ROT_W
) (
    input  logic [fft_ctrl_pkg::STAGE_W-1:0] i_s,
    input  logic [ADDR_W-2:0]                i_k,
    input  logic [fft_ctrl_pkg::LOG2N_W-1:0] i_log2n,
    output logic [ADDR_W-1:0]                o_a,
    output logic [ADDR_W-1:0]                o_b,
    output logic [ROT_W-1:0]                 o_rot
);
    import fft_ctrl_pkg::*;

    logic [LOG2N_W-1:0] w_hsh;
    logic [LOG2N_W-1:0] w_rsh;
    logic [ADDR_W-1:0]  w_k;
    logic [ADDR_W-1:0]  w_half;
    logic [ADDR_W-1:0]  w_j;
    logic [ADDR_W-1:0]  w_g;

    // half is a power of two, so mod/div reduce to mask/shift by log2(half)
    always_comb begin
        w_hsh  = i_log2n - LOG2N_W'(i_s) - LOG2N_W'(1);
        w_rsh  = LOG2N_W'(i_s) + LOG2N_W'(MAX_LOG2N) - i_log2n;
        w_k    = {1'b0, i_k};
        w_half = ADDR_W'(1) << w_hsh;
        w_j    = w_k & (w_half - ADDR_W'(1));
        w_g    = w_k >> w_hsh;
        o_a    = (w_g << (w_hsh + LOG2N_W'(1))) | w_j;
        o_b    = o_a + w_half;
        o_rot  = ROT_W'(w_j << w_rsh);
    end

endmodule

// File: rtl/fft_stage_seq.sv
// In-place radix-2 DIF FFT sequencer: one butterfly issue per cycle, write-back
// delayed by DP_LAT. Per-stage result scaling is added by FFT_STAGE_SCALE_EN.
module fft_stage_seq #(
    parameter int unsigned MAX_LOG2N = fft_ctrl_pkg::MAX_LOG2N,
    parameter int unsigned DP_LAT    = 2,
    parameter int unsigned ADDR_W    = fft_ctrl_pkg::ADDR_W,
    parameter int unsigned ROT_W     = fft_ctrl_pkg::ROT_W
) (
    input  logic           clk,
    input  logic           rst,
    fft_stage_seq_if.slave bus
);
    import fft_ctrl_pkg::*;

    localparam int unsigned KW = ADDR_W - 1;
    localparam int unsigned CW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    state_t             r_state;
    logic [LOG2N_W-1:0] r_log2n;
    logic [STAGE_W-1:0] r_s;
    logic [KW-1:0]      r_k;
    logic [CW-1:0]      r_dcnt;
    logic               r_busy;
    logic               r_done;
    logic               r_cfg_err;
    logic               r_rd_en;

    logic [DP_LAT-1:0]  r_pen;
    logic [ADDR_W-1:0]  r_pa [DP_LAT];
    logic [ADDR_W-1:0]  r_pb [DP_LAT];

    logic [ADDR_W-1:0]  w_a;
    logic [ADDR_W-1:0]  w_b;
    logic [ROT_W-1:0]   w_rot;
    logic [ADDR_W-1:0]  w_rd_a;
    logic [ADDR_W-1:0]  w_rd_b;
    logic [ADDR_W-1:0]  w_klast;
    logic               w_last_stage;
    logic               w_cfg_ok;

`ifdef FFT_STAGE_SCALE_EN
    logic [MAX_LOG2N-1:0] r_scale_mask;
    logic [STAGE_W-1:0]   r_ps [DP_LAT];
`endif

    fft_addr_gen #(
        .MAX_LOG2N (MAX_LOG2N),
        .ADDR_W    (ADDR_W),
        .ROT_W     (ROT_W)
    ) u_addr_gen (
        .i_s     (r_s),
        .i_k     (r_k),
        .i_log2n (r_log2n),
        .o_a     (w_a),
        .o_b     (w_b),
        .o_rot   (w_rot)
    );

    assign w_klast      = (ADDR_W'(1) << (r_log2n - LOG2N_W'(1))) - ADDR_W'(1);
    assign w_last_stage = (LOG2N_W'(r_s) == r_log2n - LOG2N_W'(1));
    assign w_cfg_ok     = (bus.log2n != '0) && (bus.log2n <= LOG2N_W'(MAX_LOG2N));

    // Issue addresses are forced to zero outside RUN so idle outputs stay quiet
    assign w_rd_a = r_rd_en ? w_a : '0;
    assign w_rd_b = r_rd_en ? w_b : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_log2n   <= '0;
            r_s       <= '0;
            r_k       <= '0;
            r_dcnt    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_rd_en   <= 1'b0;
`ifdef FFT_STAGE_SCALE_EN
            r_scale_mask <= '0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (bus.abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_rd_en <= 1'b0;
                r_s     <= '0;
                r_k     <= '0;
                r_dcnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            if (w_cfg_ok) begin
                                r_state <= RUN;
                                r_log2n <= bus.log2n;
                                r_s     <= '0;
                                r_k     <= '0;
                                r_busy  <= 1'b1;
                                r_rd_en <= 1'b1;
`ifdef FFT_STAGE_SCALE_EN
                                r_scale_mask <= bus.scale_mask;
`endif
                            end else begin
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if ({1'b0, r_k} == w_klast) begin
                            r_state <= DRAIN;
                            r_rd_en <= 1'b0;
                            r_dcnt  <= '0;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (r_dcnt == CW'(DP_LAT - 1)) begin
                            if (w_last_stage) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_s     <= '0;
                            end else begin
                                r_state <= RUN;
                                r_s     <= r_s + 1'b1;
                                r_k     <= '0;
                                r_rd_en <= 1'b1;
                            end
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Write-back delay line; abort flushes it so no stale writes land
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pen <= '0;
            for (int unsigned i = 0; i < DP_LAT; i++) begin
                r_pa[i] <= '0;
                r_pb[i] <= '0;
`ifdef FFT_STAGE_SCALE_EN
                r_ps[i] <= '0;
`endif
            end
        end else if (bus.abort) begin
            r_pen <= '0;
            for (int unsigned i = 0; i < DP_LAT; i++) begin
                r_pa[i] <= '0;
                r_pb[i] <= '0;
`ifdef FFT_STAGE_SCALE_EN
                r_ps[i] <= '0;
`endif
            end
        end else begin
            r_pen[0] <= r_rd_en;
            r_pa[0]  <= w_rd_a;
            r_pb[0]  <= w_rd_b;
`ifdef FFT_STAGE_SCALE_EN
            r_ps[0]  <= r_s;
`endif
            for (int unsigned i = 1; i < DP_LAT; i++) begin
                r_pen[i] <= r_pen[i-1];
                r_pa[i]  <= r_pa[i-1];
                r_pb[i]  <= r_pb[i-1];
`ifdef FFT_STAGE_SCALE_EN
                r_ps[i]  <= r_ps[i-1];
`endif
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.stage     = r_s;
    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr_a = w_rd_a;
    assign bus.rd_addr_b = w_rd_b;
    assign bus.rot       = r_rd_en ? w_rot : '0;
    assign bus.wr_en     = r_pen[DP_LAT-1];
    assign bus.wr_addr_a = r_pa[DP_LAT-1];
    assign bus.wr_addr_b = r_pb[DP_LAT-1];
`ifdef FFT_STAGE_SCALE_EN
    assign bus.wr_scale  = r_pen[DP_LAT-1] & r_scale_mask[r_ps[DP_LAT-1]];
`endif

endmodule
